// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage -- instruction-decode stage of the 5-stage MIPS pipeline.
//
// Decodes the IF/ID word, reads the 32x32 register file (written by
// write-back), and registers the ID/EX bundle for execute. It also detects
// load-use hazards and inserts a control bubble on a stall or a branch flush.
//
// Ports:
//   clk                       pipeline clock; all state updates on posedge
//   rst_n                     synchronous active-low reset
//   in_IF_ID[63:0]            [63:32] PC+4, [31:0] instruction
//   in_flush                  squash the current decode (bubble)
//   in_regWrite               write-back enable
//   in_writeReg[4:0]          write-back destination register
//   in_writeData[31:0]        write-back data
//   out_stall                 combinational load-use stall to fetch
//   out_WB[1:0]               {RegWrite, MemtoReg}
//   out_M[2:0]                {Branch, MemRead, MemWrite}
//   out_EX[3:0]               {ALUOp[1:0], RegDst, ALUSrc}
//   out_incremented_PC[31:0]  registered PC+4
//   out_regData1/2[31:0]      registered rs / rt read data
//   out_sign_extended_offset  registered sign-extended instr[15:0]
//   out_rs/out_rt/out_rd      registered register fields
// ---------------------------------------------------------------------------
module id_stage #(
    parameter logic BYPASS_EN = 1'b1,
    parameter logic HAZARD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] in_IF_ID,
    input  logic        in_flush,
    input  logic        in_regWrite,
    input  logic [4:0]  in_writeReg,
    input  logic [31:0] in_writeData,
    output logic        out_stall,
    output logic [1:0]  out_WB,
    output logic [2:0]  out_M,
    output logic [3:0]  out_EX,
    output logic [31:0] out_incremented_PC,
    output logic [31:0] out_regData1,
    output logic [31:0] out_regData2,
    output logic [31:0] out_sign_extended_offset,
    output logic [4:0]  out_rs,
    output logic [4:0]  out_rt,
    output logic [4:0]  out_rd
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // Instruction fields
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;

    assign instr  = in_IF_ID[31:0];
    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];

    // -----------------------------------------------------------------------
    // Register file: synchronous write, combinational read
    // -----------------------------------------------------------------------
    logic [31:0] regs_reg [32];
    logic        wr_en;

    // Register 0 is hard-wired to zero, so writes to it are never performed.
    assign wr_en = in_regWrite && (in_writeReg != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_en) begin
            regs_reg[in_writeReg] <= in_writeData;
        end
    end

    // Two read ports: index 0 = rs, index 1 = rt.
    logic [4:0]  rd_addr [2];
    logic [31:0] rd_data [2];

    assign rd_addr[0] = rs;
    assign rd_addr[1] = rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
            always_comb begin
                rd_data[gi] = regs_reg[rd_addr[gi]];
                // A write landing this same edge is forwarded so the decoded
                // operand is never one write-back stale.
                if (BYPASS_EN && wr_en && (in_writeReg == rd_addr[gi])) begin
                    rd_data[gi] = in_writeData;
                end
                if (rd_addr[gi] == 5'd0) begin
                    rd_data[gi] = '0;
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Control decode
    // -----------------------------------------------------------------------
    logic [1:0] wb_next;
    logic [2:0] m_next;
    logic [3:0] ex_next;

    always_comb begin
        wb_next = 2'b00;
        m_next  = 3'b000;
        ex_next = 4'b0000;
        unique case (opcode)
            OP_RTYPE: begin wb_next = 2'b10; m_next = 3'b000; ex_next = 4'b1010; end
            OP_LW:    begin wb_next = 2'b11; m_next = 3'b010; ex_next = 4'b0001; end
            OP_SW:    begin wb_next = 2'b00; m_next = 3'b001; ex_next = 4'b0001; end
            OP_BEQ:   begin wb_next = 2'b00; m_next = 3'b100; ex_next = 4'b0100; end
            OP_ADDI:  begin wb_next = 2'b10; m_next = 3'b000; ex_next = 4'b0001; end
            default:  begin wb_next = 2'b00; m_next = 3'b000; ex_next = 4'b0000; end
        endcase
    end

    // -----------------------------------------------------------------------
    // Load-use hazard: the instruction in EX is a load whose destination (rt)
    // is a source of the instruction being decoded. Only R-type, sw and beq
    // actually read rt as a source.
    // -----------------------------------------------------------------------
    logic uses_rt;

    assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);

    assign out_stall = HAZARD_EN && out_M[1] && (out_rt != 5'd0) &&
                       ((out_rt == rs) || (uses_rt && (out_rt == rt)));

    // -----------------------------------------------------------------------
    // ID/EX pipeline register
    // -----------------------------------------------------------------------
    logic bubble;

    assign bubble = in_flush || out_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_WB                   <= '0;
            out_M                    <= '0;
            out_EX                   <= '0;
            out_incremented_PC       <= '0;
            out_regData1             <= '0;
            out_regData2             <= '0;
            out_sign_extended_offset <= '0;
            out_rs                   <= '0;
            out_rt                   <= '0;
            out_rd                   <= '0;
        end else begin
            // A bubble only zeroes the controls; data fields are don't-care
            // downstream and simply load the current decode.
            out_WB                   <= bubble ? 2'b00   : wb_next;
            out_M                    <= bubble ? 3'b000  : m_next;
            out_EX                   <= bubble ? 4'b0000 : ex_next;
            out_incremented_PC       <= in_IF_ID[63:32];
            out_regData1             <= rd_data[0];
            out_regData2             <= rd_data[1];
            out_sign_extended_offset <= {{16{instr[15]}}, instr[15:0]};
            out_rs                   <= rs;
            out_rt                   <= rt;
            out_rd                   <= rd;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] se;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } idex_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [63:0] in_IF_ID;
    logic        in_flush;
    logic        in_regWrite;
    logic [4:0]  in_writeReg;
    logic [31:0] in_writeData;

    logic        out_stall;
    logic [1:0]  out_WB;
    logic [2:0]  out_M;
    logic [3:0]  out_EX;
    logic [31:0] out_incremented_PC, out_regData1, out_regData2, out_sign_extended_offset;
    logic [4:0]  out_rs, out_rt, out_rd;

    // Second instance with hazard detection disabled: only its stall is observed.
    logic        nh_stall;
    logic [1:0]  nh_WB;
    logic [2:0]  nh_M;
    logic [3:0]  nh_EX;
    logic [31:0] nh_pc, nh_d1, nh_d2, nh_se;
    logic [4:0]  nh_rs, nh_rt, nh_rd;

    id_stage #(.BYPASS_EN(1'b1), .HAZARD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_IF_ID(in_IF_ID), .in_flush(in_flush),
        .in_regWrite(in_regWrite), .in_writeReg(in_writeReg), .in_writeData(in_writeData),
        .out_stall(out_stall), .out_WB(out_WB), .out_M(out_M), .out_EX(out_EX),
        .out_incremented_PC(out_incremented_PC), .out_regData1(out_regData1),
        .out_regData2(out_regData2), .out_sign_extended_offset(out_sign_extended_offset),
        .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd)
    );

    id_stage #(.BYPASS_EN(1'b1), .HAZARD_EN(1'b0)) dut_nh (
        .clk(clk), .rst_n(rst_n), .in_IF_ID(in_IF_ID), .in_flush(in_flush),
        .in_regWrite(in_regWrite), .in_writeReg(in_writeReg), .in_writeData(in_writeData),
        .out_stall(nh_stall), .out_WB(nh_WB), .out_M(nh_M), .out_EX(nh_EX),
        .out_incremented_PC(nh_pc), .out_regData1(nh_d1),
        .out_regData2(nh_d2), .out_sign_extended_offset(nh_se),
        .out_rs(nh_rs), .out_rt(nh_rt), .out_rd(nh_rd)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    idex_t q_out[$];
    bit    q_stall[$];

    // Reference model state
    logic [31:0] m_regs [32];
    idex_t       m_out;
    bit          exp_stall;
    logic [31:0] pc_v;

    // Control table: {WB, M, EX}
    function automatic logic [8:0] ctrl_of(input logic [5:0] op);
        case (op)
            6'h00:   return {2'b10, 3'b000, 4'b1010};
            6'h23:   return {2'b11, 3'b010, 4'b0001};
            6'h2B:   return {2'b00, 3'b001, 4'b0001};
            6'h04:   return {2'b00, 3'b100, 4'b0100};
            6'h08:   return {2'b10, 3'b000, 4'b0001};
            default: return 9'd0;
        endcase
    endfunction

    function automatic logic [31:0] read_reg(input logic [4:0] a, input logic we,
                                             input logic [4:0] wr, input logic [31:0] wd);
        if (a == 0) return 32'd0;
        if (we && wr == a) return wd;
        return m_regs[a];
    endfunction

    // One clock of stimulus; the model predicts the stall seen this cycle and
    // the ID/EX bundle after the coming edge.
    task automatic step(input logic rst_v, input logic [31:0] ins, input logic fl,
                        input logic we, input logic [4:0] wr, input logic [31:0] wd);
        idex_t       nxt;
        logic [5:0]  op;
        logic [4:0]  rs, rt;
        bit          uses_rt;
        logic [8:0]  c;
        @(negedge clk);
        rst_n        = rst_v;
        in_IF_ID     = {pc_v, ins};
        in_flush     = fl;
        in_regWrite  = we;
        in_writeReg  = wr;
        in_writeData = wd;
        #1;
        cyc++;
        op = ins[31:26];
        rs = ins[25:21];
        rt = ins[20:16];
        uses_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
        exp_stall = m_out.m[1] && (m_out.rt != 0) &&
                    ((m_out.rt == rs) || (uses_rt && m_out.rt == rt));
        q_stall.push_back(exp_stall);
        if (!rst_v) begin
            nxt = '0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else begin
            c = (fl || exp_stall) ? 9'd0 : ctrl_of(op);
            nxt.wb = c[8:7];
            nxt.m  = c[6:4];
            nxt.ex = c[3:0];
            nxt.pc = pc_v;
            nxt.d1 = read_reg(rs, we, wr, wd);
            nxt.d2 = read_reg(rt, we, wr, wd);
            nxt.se = {{16{ins[15]}}, ins[15:0]};
            nxt.rs = rs;
            nxt.rt = rt;
            nxt.rd = ins[15:11];
            if (we && wr != 0) m_regs[wr] = wd;
        end
        q_out.push_back(nxt);
        m_out = nxt;
    endtask

    // Fetch emulation: repeat the same instruction while the model says stall.
    task automatic fetch(input logic [31:0] ins, input logic fl, input logic we,
                         input logic [4:0] wr, input logic [31:0] wd);
        int guard;
        step(1'b1, ins, fl, we, wr, wd);
        guard = 0;
        while (exp_stall && guard < 4) begin
            step(1'b1, ins, 1'b0, 1'b0, 5'd0, 32'd0);
            guard++;
        end
        pc_v = pc_v + 32'd4;
    endtask

    // Monitor: stall is checked late in the low phase, the registered bundle
    // just after each rising edge.
    initial begin
        idex_t e, a;
        bit    s;
        forever begin
            @(negedge clk);
            #4;
            if (q_stall.size() > 0) begin
                s = q_stall.pop_front();
                checks++;
                if (out_stall !== s) begin
                    errors++;
                    $display("FAIL stall cyc=%0d got=%b want=%b", cyc, out_stall, s);
                end
                checks++;
                if (nh_stall !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hazard_off cyc=%0d got=%b want=0", cyc, nh_stall);
                end
            end
            @(posedge clk);
            #1;
            if (q_out.size() > 0) begin
                e = q_out.pop_front();
                a = {out_WB, out_M, out_EX, out_incremented_PC, out_regData1, out_regData2,
                     out_sign_extended_offset, out_rs, out_rt, out_rd};
                checks++;
                if ({a.wb, a.m, a.ex} !== {e.wb, e.m, e.ex}) begin
                    errors++;
                    $display("FAIL ctrl cyc=%0d got WB=%b M=%b EX=%b want WB=%b M=%b EX=%b",
                             cyc, a.wb, a.m, a.ex, e.wb, e.m, e.ex);
                end
                checks++;
                if ({a.pc, a.d1, a.d2, a.se, a.rs, a.rt, a.rd} !==
                    {e.pc, e.d1, e.d2, e.se, e.rs, e.rt, e.rd}) begin
                    errors++;
                    $display("FAIL data cyc=%0d got pc=%h d1=%h d2=%h se=%h rs=%0d rt=%0d rd=%0d want pc=%h d1=%h d2=%h se=%h rs=%0d rt=%0d rd=%0d",
                             cyc, a.pc, a.d1, a.d2, a.se, a.rs, a.rt, a.rd,
                             e.pc, e.d1, e.d2, e.se, e.rs, e.rt, e.rd);
                end
            end
        end
    end

    initial begin
        logic [31:0] ins;
        logic [5:0]  op;
        rst_n        = 1'b0;
        in_IF_ID     = '0;
        in_flush     = 1'b0;
        in_regWrite  = 1'b1;
        in_writeReg  = 5'd5;
        in_writeData = 32'h0000AAAA;
        m_out        = '0;
        exp_stall    = 1'b0;
        pc_v         = 32'd4;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;

        // Reset with a concurrent write-back that must be dropped
        step(1'b0, 32'hFC000000, 1'b0, 1'b1, 5'd5, 32'h0000AAAA);
        step(1'b0, 32'hFC000000, 1'b0, 1'b1, 5'd5, 32'h0000AAAA);
        fetch(32'h00A00020, 1'b0, 1'b0, 5'd0, 32'd0);          // reads R5
        // Write R8, then add $3,$8,$8
        fetch(32'hFC000000, 1'b0, 1'b1, 5'd8, 32'h12345678);
        fetch(32'h01081820, 1'b0, 1'b0, 5'd0, 32'd0);
        // lw $9,-4($8)
        fetch(32'h8D09FFFC, 1'b0, 1'b0, 5'd0, 32'd0);
        // Load-use: lw $9,0($8); add $10,$9,$8
        fetch(32'h8D090000, 1'b0, 1'b0, 5'd0, 32'd0);
        fetch(32'h01285020, 1'b0, 1'b0, 5'd0, 32'd0);
        // Same-cycle bypass on rs = 4
        fetch(32'h00800820, 1'b0, 1'b1, 5'd4, 32'hDEADBEEF);
        // Write to R0 ignored, R0 reads 0 (same cycle and next)
        fetch(32'h00000020, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
        fetch(32'h00000020, 1'b0, 1'b0, 5'd0, 32'd0);
        // Flush together with a stall
        fetch(32'h8D090000, 1'b0, 1'b0, 5'd0, 32'd0);
        fetch(32'h01285020, 1'b1, 1'b0, 5'd0, 32'd0);
        // Unknown opcode 0x3F
        fetch(32'hFD2A1234, 1'b0, 1'b0, 5'd0, 32'd0);

        // Randomized traffic with small register numbers to provoke hazards
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 6))
                0:       op = 6'h00;
                1:       op = 6'h23;
                2:       op = 6'h2B;
                3:       op = 6'h04;
                4:       op = 6'h08;
                5:       op = 6'($urandom);
                default: op = 6'h23;
            endcase
            ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            if ($urandom_range(0, 59) == 0) begin
                step(1'b0, ins, 1'($urandom_range(0, 1)), 1'b1,
                     5'($urandom_range(0, 7)), $urandom);
            end else begin
                fetch(ins, ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
                      5'($urandom_range(0, 7)), $urandom);
            end
        end

        repeat (3) @(negedge clk);
        checks++;
        if (q_out.size() != 0 || q_stall.size() != 0) begin
            errors++;
            $display("FAIL drain got out=%0d stall=%0d pending want 0", q_out.size(), q_stall.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
